sdram_refresh_scheduler: RTL and testbench

- Parametrised refresh-debt scheduler for the chip RAM SDRAM controller, clocked from CLK7 so the refresh rate is independent of CPU clock and configuration.
- Generates a refresh credit every INTERVAL CLK7 ticks and accumulates credits as debt, up to MAX_DEBT, so the controller can postpone refreshes around DMA and CPU bursts.
- Presents normal and urgent request levels to the controller.
- Retires debt through a toggle handshake from the CLK80 controller domain.

---
 rtl/sdram_refresh_scheduler.sv | 138 +++++++++++++
 tb/tb_sdram_refresh_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_refresh_scheduler.sv
// Refresh-debt scheduler for the chip RAM SDRAM controller.
// Runs on CLK7 so the refresh rate does not depend on the CPU clock. It earns one refresh
// credit every interval, keeps unpaid credits as debt, and retires debt when the CLK80
// controller toggles REF_DONE_TGL. A credit earned while the debt is full is lost, and that
// loss sets the sticky OVERFLOW flag.

module sdram_refresh_scheduler #(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned INTERVAL     = 54,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_LEVEL = 6,
  parameter int unsigned DEBT_WIDTH   = 4
) (
  input  logic                  CLK7,
  input  logic                  REF_RESET,
  input  logic                  ENABLE,
  input  logic [CNT_WIDTH-1:0]  INTERVAL_CFG,
  input  logic                  REF_DONE_TGL,
  input  logic                  CLR_OVF,
  output logic                  REFRESH,
  output logic                  URGENT,
  output logic                  OVERFLOW,
  output logic [DEBT_WIDTH-1:0] DEBT
);

  localparam logic [CNT_WIDTH-1:0]  IntervalDef = CNT_WIDTH'(INTERVAL);
  localparam logic [CNT_WIDTH-1:0]  CntOne      = CNT_WIDTH'(1);
  localparam logic [DEBT_WIDTH-1:0] MaxDebt     = DEBT_WIDTH'(MAX_DEBT);
  localparam logic [DEBT_WIDTH-1:0] UrgentLevel = DEBT_WIDTH'(URGENT_LEVEL);
  localparam logic [DEBT_WIDTH-1:0] DebtOne     = DEBT_WIDTH'(1);

  // Interval counter.
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] iv;
  logic [CNT_WIDTH-1:0] iv_last;
  logic                 tick;

  // Done-toggle synchroniser. Bit 0 samples the input, and bits 1 and 2 form the edge
  // detector.
  logic [2:0] sync_q, sync_d;
  logic       done;

  // Debt and the flags derived from it.
  logic [DEBT_WIDTH-1:0] debt_q, debt_d;
  logic                  refresh_q, refresh_d;
  logic                  urgent_q, urgent_d;
  logic                  ovf_q, ovf_d;
  logic                  ovf_set;

  // Pick the interval, flag the last count of each interval, and compute the next count.
  always_comb begin
    iv      = (INTERVAL_CFG == '0) ? IntervalDef : INTERVAL_CFG;
    iv_last = iv - CntOne;
    tick    = 1'b0;
    cnt_d   = cnt_q;
    if (!ENABLE) begin
      cnt_d = '0;
    end else if (cnt_q == iv_last) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      // If the interval was lowered below the count, the count rolls over naturally.
      cnt_d = cnt_q + CntOne;
    end
  end

  // Shift the done toggle through the synchroniser; any edge out of bit 1 is one refresh.
  always_comb begin
    sync_d = {sync_q[1:0], REF_DONE_TGL};
    done   = sync_q[1] ^ sync_q[2];
  end

  // Add a credit on a tick and retire one on a done. The debt saturates at 0 and at MAX_DEBT.
  always_comb begin
    debt_d  = debt_q;
    ovf_set = 1'b0;
    if (!ENABLE) begin
      // Done edges that arrive while disabled are dropped here.
      debt_d = '0;
    end else if (tick && !done) begin
      if (debt_q < MaxDebt) begin
        debt_d = debt_q + DebtOne;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (done && !tick) begin
      // A done with no debt is a spurious refresh and is ignored.
      if (debt_q != '0) begin
        debt_d = debt_q - DebtOne;
      end
    end
  end

  // Derive the registered flags from the next debt so they change on the same edge as DEBT.
  always_comb begin
    refresh_d = (debt_d != '0);
    urgent_d  = (debt_d >= UrgentLevel);
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Hold the counter, the debt and the flags. All of them clear on reset.
  always_ff @(posedge CLK7 or posedge REF_RESET) begin
    if (REF_RESET) begin
      cnt_q     <= '0;
      debt_q    <= '0;
      refresh_q <= 1'b0;
      urgent_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      debt_q    <= debt_d;
      refresh_q <= refresh_d;
      urgent_q  <= urgent_d;
      ovf_q     <= ovf_d;
    end
  end

  // Hold the synchroniser. Reset loads the live toggle level so no edge appears after reset.
  always_ff @(posedge CLK7 or posedge REF_RESET) begin
    if (REF_RESET) begin
      sync_q <= {3{REF_DONE_TGL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign REFRESH  = refresh_q;
  assign URGENT   = urgent_q;
  assign OVERFLOW = ovf_q;
  assign DEBT     = debt_q;

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Self-checking bench for sdram_refresh_scheduler. It uses directed scenarios and then
// randomized traffic, and checks the outputs against an edge-level behavioural model.

module tb_sdram_refresh_scheduler;

  logic       clk7;
  logic       ref_reset;
  logic       enable;
  logic [7:0] interval_cfg;
  logic       ref_done_tgl;
  logic       clr_ovf;
  logic       refresh;
  logic       urgent;
  logic       overflow;
  logic [3:0] debt;

  int total = 0;
  int bad   = 0;

  // Model state.
  int   m_phase;
  int   m_debt;
  bit   m_ovf;
  int   edge_n;
  bit   m_last_tgl;
  int   done_q[$];

  sdram_refresh_scheduler dut (
    .CLK7         (clk7),
    .REF_RESET    (ref_reset),
    .ENABLE       (enable),
    .INTERVAL_CFG (interval_cfg),
    .REF_DONE_TGL (ref_done_tgl),
    .CLR_OVF      (clr_ovf),
    .REFRESH      (refresh),
    .URGENT       (urgent),
    .OVERFLOW     (overflow),
    .DEBT         (debt)
  );

  initial begin
    clk7 = 1'b0;
    forever #5 clk7 = ~clk7;
  end

  function automatic logic [6:0] obs();
    return {refresh, urgent, overflow, debt};
  endfunction

  function automatic logic [6:0] mvec();
    return {(m_debt >= 1), (m_debt >= 6), m_ovf, 4'(m_debt)};
  endfunction

  // Advance one clock edge. The model sees the same inputs as the DUT at that edge.
  // A toggle seen at edge k retires debt at edge k+2.
  task automatic step();
    bit en, tg, clr, tick, done, set;
    int iv;
    en  = enable;
    tg  = ref_done_tgl;
    clr = clr_ovf;
    iv  = (interval_cfg == 0) ? 54 : int'(interval_cfg);
    @(posedge clk7);
    edge_n++;
    done = 0;
    set  = 0;
    tick = 0;
    if (done_q.size() > 0 && done_q[0] == edge_n) begin
      done = 1;
      void'(done_q.pop_front());
    end
    if (tg != m_last_tgl) done_q.push_back(edge_n + 2);
    m_last_tgl = tg;
    if (!en) begin
      m_phase = 0;
      m_debt  = 0;
    end else begin
      if (m_phase == iv - 1) begin
        tick    = 1;
        m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % 256;
      end
      if (tick && !done) begin
        if (m_debt < 8) m_debt++;
        else set = 1;
      end else if (done && !tick && m_debt > 0) begin
        m_debt--;
      end
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
    #1;
  endtask

  // Pulse reset between clock edges and return the outputs captured while reset is high.
  task automatic pulse_reset(output logic [6:0] snap);
    #2 ref_reset = 1'b1;
    #1 snap = obs();
    #2 ref_reset = 1'b0;
    m_phase    = 0;
    m_debt     = 0;
    m_ovf      = 0;
    m_last_tgl = ref_done_tgl;
    done_q.delete();
  endtask

  task automatic test_reset();
    logic [6:0] snap;
    enable = 0; interval_cfg = 0; ref_done_tgl = 0; clr_ovf = 0; ref_reset = 0;
    #1;
    pulse_reset(snap);
    total++;
    if (snap !== 7'h00) begin
      bad++; $display("FAIL reset_async: got %h want 00", snap);
    end
    step();
    total++;
    if (obs() !== 7'h00) begin
      bad++; $display("FAIL reset_hold: got %h want 00", obs());
    end
  endtask

  task automatic test_default_interval();
    logic [6:0] snap;
    pulse_reset(snap);
    enable = 1; interval_cfg = 0;
    for (int i = 1; i <= 108; i++) begin
      step();
      total++;
      if (obs() !== mvec()) begin
        bad++; $display("FAIL default_model edge %0d: got %h want %h", i, obs(), mvec());
      end
      if (i == 53 || i == 54 || i == 108) begin
        total++;
        if ({refresh, debt} !== ((i == 53) ? 5'h00 : (i == 54) ? 5'h11 : 5'h12)) begin
          bad++; $display("FAIL default_edge%0d: got refresh=%b debt=%0d", i, refresh, debt);
        end
      end
    end
  endtask

  task automatic test_urgent_overflow();
    logic [6:0] snap;
    pulse_reset(snap);
    enable = 1; interval_cfg = 4;
    for (int i = 1; i <= 44; i++) begin
      clr_ovf = (i == 37);
      step();
      total++;
      if (obs() !== mvec()) begin
        bad++; $display("FAIL urgent_model edge %0d: got %h want %h", i, obs(), mvec());
      end
      if (i == 23) begin
        total++;
        if (urgent !== 1'b0) begin
          bad++; $display("FAIL urgent_early: got %b want 0", urgent);
        end
      end
      if (i == 24) begin
        total++;
        if ({urgent, debt} !== 5'h16) begin
          bad++; $display("FAIL urgent_rise: got urgent=%b debt=%0d want 1/6", urgent, debt);
        end
      end
      if (i == 32) begin
        total++;
        if (debt !== 4'd8) begin
          bad++; $display("FAIL debt_sat: got %0d want 8", debt);
        end
      end
      if (i == 35 || i == 36 || i == 37 || i == 40) begin
        total++;
        if (overflow !== ((i == 36 || i == 40) ? 1'b1 : 1'b0)) begin
          bad++; $display("FAIL ovf_edge%0d: got %b", i, overflow);
        end
      end
    end
    clr_ovf = 0;
  endtask

  task automatic test_handshake();
    logic [6:0] snap;
    pulse_reset(snap);
    enable = 1; interval_cfg = 4;
    for (int i = 1; i <= 12; i++) step();
    total++;
    if (debt !== 4'd3) begin
      bad++; $display("FAIL hs_setup: got %0d want 3", debt);
    end
    interval_cfg = 255;
    for (int j = 13; j <= 24; j++) begin
      if (j == 13 || j == 16 || j == 19) ref_done_tgl = ~ref_done_tgl;
      step();
      total++;
      if (obs() !== mvec()) begin
        bad++; $display("FAIL hs_model edge %0d: got %h want %h", j, obs(), mvec());
      end
      if (j == 14 || j == 15) begin
        total++;
        if (debt !== ((j == 14) ? 4'd3 : 4'd2)) begin
          bad++; $display("FAIL hs_latency edge %0d: got %0d", j, debt);
        end
      end
      if (j == 21) begin
        total++;
        if ({refresh, debt} !== 5'h00) begin
          bad++; $display("FAIL hs_drain: got refresh=%b debt=%0d want 0/0", refresh, debt);
        end
      end
    end
  endtask

  task automatic test_collision();
    logic [6:0] snap;
    pulse_reset(snap);
    enable = 1; interval_cfg = 4;
    for (int i = 1; i <= 39; i++) begin
      if (i == 34) ref_done_tgl = ~ref_done_tgl;
      step();
      total++;
      if (obs() !== mvec()) begin
        bad++; $display("FAIL coll_model edge %0d: got %h want %h", i, obs(), mvec());
      end
      if (i == 36 || i == 39) begin
        total++;
        if ({overflow, debt} !== 5'h08) begin
          bad++; $display("FAIL coll_edge%0d: got ovf=%b debt=%0d want 0/8", i, overflow, debt);
        end
      end
    end
    pulse_reset(snap);
    enable = 1; interval_cfg = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 1) ref_done_tgl = ~ref_done_tgl;
      step();
      if (i >= 3) begin
        total++;
        if (debt !== 4'd0) begin
          bad++; $display("FAIL spurious_done edge %0d: got %0d want 0", i, debt);
        end
      end
    end
  endtask

  task automatic test_enable_reset();
    logic [6:0] snap;
    pulse_reset(snap);
    enable = 1; interval_cfg = 1;
    for (int i = 1; i <= 10; i++) step();
    interval_cfg = 255;
    for (int j = 1; j <= 9; j++) begin
      if (j == 1 || j == 4 || j == 7) ref_done_tgl = ~ref_done_tgl;
      step();
    end
    total++;
    if ({overflow, debt} !== 5'h15) begin
      bad++; $display("FAIL en_setup: got ovf=%b debt=%0d want 1/5", overflow, debt);
    end
    enable = 0;
    step();
    total++;
    if (obs() !== 7'h10) begin
      bad++; $display("FAIL disable: got %h want 10", obs());
    end
    enable = 1; interval_cfg = 4;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3 || i == 4) begin
        total++;
        if (debt !== ((i == 3) ? 4'd0 : 4'd1)) begin
          bad++; $display("FAIL reenable_count edge %0d: got %0d", i, debt);
        end
      end
    end
    ref_done_tgl = 1;
    pulse_reset(snap);
    total++;
    if (snap !== 7'h00) begin
      bad++; $display("FAIL midreset_async: got %h want 00", snap);
    end
    interval_cfg = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (debt !== 4'(i)) begin
        bad++; $display("FAIL tgl_through_reset edge %0d: got %0d want %0d", i, debt, i);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] snap;
    int since = 10;
    pulse_reset(snap);
    interval_cfg = 8'($urandom_range(1, 12));
    for (int i = 0; i < 4000; i++) begin
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 99) == 0) interval_cfg = 8'($urandom_range(0, 12));
      clr_ovf = ($urandom_range(0, 40) == 0);
      if (since >= 2 && $urandom_range(0, ((i / 400) % 2 == 0) ? 30 : 2) == 0) begin
        ref_done_tgl = ~ref_done_tgl;
        since = 0;
      end
      if ($urandom_range(0, 799) == 0) begin
        pulse_reset(snap);
        total++;
        if (snap !== 7'h00) begin
          bad++; $display("FAIL rand_reset: got %h want 00", snap);
        end
      end
      step();
      since++;
      total++;
      if (obs() !== mvec()) begin
        bad++; $display("FAIL rand_model iter %0d: got %h want %h", i, obs(), mvec());
      end
    end
    clr_ovf = 0;
  endtask

  initial begin
    edge_n = 0;
    test_reset();
    test_default_interval();
    test_urgent_overflow();
    test_handshake();
    test_collision();
    test_enable_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
